mem_port_arbiter: RTL

- Shares the single-ported unified instruction/data memory between the IF stage (read-only fetch) and the MEM stage (load/store) of the pipelined core.
- Sequences each memory access through a small FSM.
- Drives per-requester stall signals into the pipeline control / hazard logic, alongside the EX-stage forwarding logic.
- Gives data accesses priority, with a streak limit so fetch cannot starve.

---
 rtl/mem_port_arbiter.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch
// (IF) and load/store (MEM). Data requests win, except that a pending fetch is
// granted after MAX_D_STREAK consecutive data grants so that fetch cannot starve.
// Every access runs through IDLE -> BUSY_x -> DONE_x and takes at least three cycles.
// Optional build macro ARB_PERF_EN adds saturating stall-cycle counters.
module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_valid,
    output logic [DW-1:0]   if_rdata,
    output logic            if_stall,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic            d_valid,
    output logic [DW-1:0]   d_rdata,
    output logic            d_stall,
    output logic            m_req,
    output logic            m_we,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    output logic [DW/8-1:0] m_be,
    input  logic            m_ready,
    input  logic [DW-1:0]   m_rdata
`ifdef ARB_PERF_EN
    ,
    output logic [31:0]     perf_if_stall_cnt,
    output logic [31:0]     perf_d_stall_cnt
`endif
);

    localparam int BW = DW / 8;

    typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D} state_t;

    state_t          state_q, state_d;
    logic            grant_d, grant_i;
    logic            mem_done;
    logic            m_req_q, m_req_d;
    logic            m_we_q, m_we_d;
    logic [AW-1:0]   m_addr_q, m_addr_d;
    logic [DW-1:0]   m_wdata_q, m_wdata_d;
    logic [BW-1:0]   m_be_q, m_be_d;
    logic [DW-1:0]   if_rdata_q, if_rdata_d;
    logic [DW-1:0]   d_rdata_q, d_rdata_d;
    logic [3:0]      streak_q, streak_d;

    // A handshake only counts while a request is actually on the bus.
    assign mem_done = m_ready & m_req_q;

    // Arbitration: data first unless the streak limit is reached with a fetch waiting.
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (state_q == IDLE) begin
            if (d_req && (!if_req || (streak_q < 4'(MAX_D_STREAK)))) begin
                grant_d = 1'b1;
            end else if (if_req) begin
                grant_i = 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = BUSY_D;
                end else if (grant_i) begin
                    state_d = BUSY_I;
                end
            end
            BUSY_I:  if (mem_done) state_d = DONE_I;
            BUSY_D:  if (mem_done) state_d = DONE_D;
            DONE_I:  state_d = IDLE;
            DONE_D:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: valid pulses come straight from the DONE states.
    always_comb begin
        if_valid = (state_q == DONE_I);
        d_valid  = (state_q == DONE_D);
        if_stall = if_req & ~if_valid;
        d_stall  = d_req & ~d_valid;
    end

    // Next values for the memory-side request, captured read data and streak count.
    always_comb begin
        m_req_d    = m_req_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        m_be_d     = m_be_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        streak_d   = streak_q;
        if (grant_d) begin
            m_req_d   = 1'b1;
            m_we_d    = d_we;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            m_be_d    = d_be;
        end else if (grant_i) begin
            m_req_d  = 1'b1;
            m_we_d   = 1'b0;
            m_addr_d = if_addr;
            m_be_d   = '1;
        end
        if ((state_q == BUSY_I) && mem_done) begin
            if_rdata_d = m_rdata;
            m_req_d    = 1'b0;
        end
        if ((state_q == BUSY_D) && mem_done) begin
            d_rdata_d = m_rdata;
            m_req_d   = 1'b0;
        end
        if (grant_d && if_req) begin
            streak_d = streak_q + 4'd1;
        end else if (grant_i || ((state_q == IDLE) && !if_req)) begin
            streak_d = 4'd0;
        end
    end

    // Datapath registers; reset drops any in-flight access.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            m_be_q     <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            streak_q   <= 4'd0;
        end else begin
            m_req_q    <= m_req_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            m_be_q     <= m_be_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            streak_q   <= streak_d;
        end
    end

    assign m_req    = m_req_q;
    assign m_we     = m_we_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign m_be     = m_be_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;

`ifdef ARB_PERF_EN
    logic [31:0] perf_if_q, perf_if_d;
    logic [31:0] perf_d_q, perf_d_d;

    // Saturating counts of stalled cycles per requester.
    always_comb begin
        perf_if_d = perf_if_q;
        perf_d_d  = perf_d_q;
        if (if_stall && (perf_if_q != 32'hFFFF_FFFF)) begin
            perf_if_d = perf_if_q + 32'd1;
        end
        if (d_stall && (perf_d_q != 32'hFFFF_FFFF)) begin
            perf_d_d = perf_d_q + 32'd1;
        end
    end

    // Stall counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_if_q <= 32'd0;
            perf_d_q  <= 32'd0;
        end else begin
            perf_if_q <= perf_if_d;
            perf_d_q  <= perf_d_d;
        end
    end

    assign perf_if_stall_cnt = perf_if_q;
    assign perf_d_stall_cnt  = perf_d_q;
`endif

endmodule
